cpu_ctrl_gen: RTL and testbench
===============================

// Module: cpu_ctrl_gen
// PURPOSE
//  Parametrised successor of the CPU top-level state manager: owns program load, init, run, end.
//  Receives a program over the UART byte stream, assembles it into words, writes instruction memory.
//  Acks the load, holds the core in reset for a programmable init wait, then releases it.
//  Counts run cycles until the core halts. Sits between the UART rx/tx FIFOs and the core/imem.
// PARAMETERS
//  BYTE_W      8    width of a UART byte
//  WORD_W      32   instruction word width; must be a multiple of BYTE_W (BPW = WORD_W/BYTE_W)
//  ADDR_W      15   imem word-address width (depth 2**ADDR_W)
//  INIT_WAIT   16   cycles spent in INIT with cpu_rstn low (>=1)
//  BIG_ENDIAN  1    1: first byte of a word lands in MSBs; 0: in LSBs
//  ACK_BYTE    8'hAA  byte transmitted once a load completes
// PORTS
//  clk          in   1        clock
//  rstn         in   1        async active-low reset
//  usr_load     in   1        1-cycle pulse: (re)start program load
//  usr_rst      in   1        1-cycle pulse: restart core without reload
//  rx_data      in   BYTE_W   received byte
//  rx_valid     in   1        rx_data valid
//  rx_ready     out  1        byte consumed when rx_valid&rx_ready
//  tx_data      out  BYTE_W   byte to send
//  tx_valid     out  1        tx_data valid, held until tx_ready
//  tx_ready     in   1        uart accepts tx_data
//  imem_we      out  1        imem write strobe (1 cycle)
//  imem_addr    out  ADDR_W   imem write address
//  imem_wdata   out  WORD_W   imem write data
//  cpu_rstn     out  1        core reset, low unless RUN/END
//  cpu_halt     in   1        core reached halt (level)
//  clock_count  out  32       cycles spent in RUN (last run)
//  led_stat     out  6        one-hot state: {IDLE,LD_SIZE,LD_DATA,ACK,INIT,RUN} ; END = 6'b0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except led_stat=6'b100000; counters, byte/word indices 0.
//  States: IDLE, LD_SIZE, LD_DATA, ACK, INIT, RUN, END.
//  IDLE: rx_ready=0. usr_load -> LD_SIZE.
//  LD_SIZE: rx_ready=1; takes 4 bytes, big-endian, as 32-bit word count N. After 4th byte:
//   N==0 -> ACK; else -> LD_DATA with addr=0. N > 2**ADDR_W: words beyond depth are
//   accepted and discarded (no imem_we), addr never wraps.
//  LD_DATA: rx_ready=1; assemble BPW bytes per BIG_ENDIAN; on the cycle after the last byte of
//   a word, imem_we=1 for exactly one cycle with imem_addr=word index; after word N -> ACK.
//   Byte handshake has no bubbles: one byte per cycle sustained.
//  ACK: rx_ready=0; tx_valid=1, tx_data=ACK_BYTE held until tx_ready; on handshake -> INIT.
//  INIT: cpu_rstn=0; clock_count cleared on entry; after INIT_WAIT cycles -> RUN.
//  RUN: cpu_rstn=1; clock_count +1 per cycle, saturates at 32'hFFFFFFFF; cpu_halt -> END
//   (halt cycle is not counted).
//  END: cpu_rstn=1, clock_count frozen; usr_rst -> INIT; usr_load -> LD_SIZE.
//  usr_rst in RUN -> INIT (clock_count cleared there); ignored in IDLE/LD_*/ACK.
//  usr_load in any state -> LD_SIZE, byte/word indices cleared, partial word dropped;
//   usr_load wins over usr_rst and over a same-cycle byte/halt event.
//  cpu_rstn low in every state except RUN/END; rx byte offered outside LD_* is not consumed.
//  Async reset mid-load: everything returns to IDLE; imem contents untouched.
// TESTING
//  Load N=2, BPW=4, bytes 00 00 00 02 | 11 22 33 44 | 55 66 77 88 -> imem[0]=32'h11223344,
//   imem[1]=32'h55667788, one tx 8'hAA, INIT 16 cycles then cpu_rstn=1.
//  Same with BIG_ENDIAN=0 -> imem[0]=32'h44332211; rx_valid gaps of 0..3 cycles -> same result.
//  N=0 -> no imem_we, ACK sent, RUN reached; tx_ready held low 5 cycles -> tx_valid stays 1.
//  RUN 100 cycles then cpu_halt -> END, clock_count=100; usr_rst -> INIT, count 0, RUN again.
//  usr_load after 6 of 8 data bytes -> LD_SIZE, no write of partial word; fresh load correct.
//  rstn low mid LD_DATA -> IDLE, led_stat=6'b100000, all strobes 0; N=2**ADDR_W+1 -> last discarded.

Source files
------------

// File: rtl/cpu_ctrl_gen_if.sv
// cpu_ctrl_gen_if -- byte-stream and instruction-memory bus of the CPU state manager.
//   rx_*   : UART receive FIFO -> controller (valid/ready)
//   tx_*   : controller -> UART transmit FIFO (valid/ready)
//   imem_* : controller -> instruction memory write port
// master modport: the controller; slave modport: the FIFOs/imem side.
interface cpu_ctrl_gen_if #(
    parameter int BYTE_W = 8,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 15
);
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid, imem_we, imem_addr, imem_wdata
    );
    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/cpu_ctrl_gen.sv
// cpu_ctrl_gen -- CPU top-level state manager: program load, init, run, end.
// Receives a word count and program bytes from the UART, assembles words and
// writes them to instruction memory, acks the load, holds the core in reset
// for INIT_WAIT cycles, then counts run cycles until the core halts.
// Ports:
//   clk, rstn     clock, async active-low reset
//   usr_load      pulse: (re)start a program load (highest priority)
//   usr_rst       pulse: restart the core without reloading (RUN/END only)
//   bus           rx/tx byte handshakes and imem write port (master side)
//   cpu_rstn      core reset, high only in RUN/END
//   cpu_halt      core halted (level)
//   clock_count   RUN cycles of the last run (saturating)
//   led_stat      one-hot {IDLE,LD_SIZE,LD_DATA,ACK,INIT,RUN}; END = 0
// WORD_W must be at least 2*BYTE_W and a multiple of it.
module cpu_ctrl_gen #(
    parameter int              BYTE_W     = 8,
    parameter int              WORD_W     = 32,
    parameter int              ADDR_W     = 15,
    parameter int              INIT_WAIT  = 16,
    parameter bit              BIG_ENDIAN = 1'b1,
    parameter logic [BYTE_W-1:0] ACK_BYTE = 8'hAA
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                usr_load,
    input  logic                usr_rst,
    cpu_ctrl_gen_if.master      bus,
    output logic                cpu_rstn,
    input  logic                cpu_halt,
    output logic [31:0]         clock_count,
    output logic [5:0]          led_stat
);
    localparam int BPW  = WORD_W / BYTE_W;
    localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int IW_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
    localparam int PW_W = WORD_W - BYTE_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LD_SIZE, S_LD_DATA, S_ACK, S_INIT, S_RUN, S_END
    } st_t;

    st_t                state;
    logic [1:0]         sz_idx;
    logic [31-BYTE_W:0] size_sh;   // size bytes received so far
    logic [31:0]        n_words;
    logic [31:0]        word_idx;  // full width so oversize loads never wrap
    logic [BI_W-1:0]    byte_idx;
    logic [PW_W-1:0]    wbuf;      // bytes of the word in progress
    logic [IW_W-1:0]    init_cnt;
    logic               rx_ready_q, tx_valid_q, imem_we_q;
    logic [BYTE_W-1:0]  tx_data_q;
    logic [ADDR_W-1:0]  imem_addr_q;
    logic [WORD_W-1:0]  imem_wdata_q;

    logic               rx_fire;
    logic [31:0]        size_nx;
    logic [WORD_W-1:0]  word_nx;

    assign rx_fire = bus.rx_valid && rx_ready_q;
    assign size_nx = {size_sh, bus.rx_data};
    // Big-endian shifts new bytes in at the bottom, little-endian at the top.
    assign word_nx = BIG_ENDIAN ? {wbuf, bus.rx_data} : {bus.rx_data, wbuf};

    assign bus.rx_ready   = rx_ready_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;

    function automatic logic [5:0] led_of(input st_t s);
        case (s)
            S_IDLE:    return 6'b100000;
            S_LD_SIZE: return 6'b010000;
            S_LD_DATA: return 6'b001000;
            S_ACK:     return 6'b000100;
            S_INIT:    return 6'b000010;
            S_RUN:     return 6'b000001;
            default:   return 6'b000000;
        endcase
    endfunction

    // State change: all state-derived outputs are registered alongside the
    // state, and per-state indices restart on every transition.
    task automatic go(input st_t s);
        state      <= s;
        led_stat   <= led_of(s);
        cpu_rstn   <= (s == S_RUN) || (s == S_END);
        rx_ready_q <= (s == S_LD_SIZE) || (s == S_LD_DATA);
        tx_valid_q <= (s == S_ACK);
        byte_idx   <= '0;
        sz_idx     <= '0;
        init_cnt   <= '0;
        if (s == S_ACK)  tx_data_q   <= ACK_BYTE;
        if (s == S_INIT) clock_count <= '0;
    endtask

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            led_stat     <= 6'b100000;
            cpu_rstn     <= 1'b0;
            clock_count  <= '0;
            sz_idx       <= '0;
            size_sh      <= '0;
            n_words      <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            wbuf         <= '0;
            init_cnt     <= '0;
            rx_ready_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            imem_we_q <= 1'b0;
            if (usr_load) begin
                go(S_LD_SIZE);
            end else begin
                case (state)
                    S_LD_SIZE: if (rx_fire) begin
                        size_sh <= size_nx[31-BYTE_W:0];
                        sz_idx  <= sz_idx + 2'd1;
                        if (sz_idx == 2'd3) begin
                            n_words  <= size_nx;
                            word_idx <= '0;
                            go((size_nx == 32'd0) ? S_ACK : S_LD_DATA);
                        end
                    end
                    S_LD_DATA: if (rx_fire) begin
                        wbuf     <= BIG_ENDIAN ? word_nx[PW_W-1:0] : word_nx[WORD_W-1:BYTE_W];
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == BI_W'(BPW - 1)) begin
                            byte_idx <= '0;
                            word_idx <= word_idx + 32'd1;
                            // Words past the memory depth are swallowed.
                            if (word_idx[31:ADDR_W] == '0) begin
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= word_idx[ADDR_W-1:0];
                                imem_wdata_q <= word_nx;
                            end
                            if (word_idx == n_words - 32'd1) go(S_ACK);
                        end
                    end
                    S_ACK: if (tx_valid_q && bus.tx_ready) go(S_INIT);
                    S_INIT: begin
                        if (init_cnt == IW_W'(INIT_WAIT - 1)) go(S_RUN);
                        else init_cnt <= init_cnt + 1'b1;
                    end
                    S_RUN: begin
                        if (usr_rst) go(S_INIT);
                        else if (cpu_halt) go(S_END);
                        else if (clock_count != 32'hFFFF_FFFF) clock_count <= clock_count + 32'd1;
                    end
                    S_END: if (usr_rst) go(S_INIT);
                    S_IDLE: ;
                    default: go(S_IDLE);
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cpu_ctrl_gen.sv
// Bench for cpu_ctrl_gen: a big-endian and a little-endian instance share one
// stimulus stream; expected imem writes and tx bytes go into queues that
// negedge monitors drain, while state/count checks are made in line.
module tb_cpu_ctrl_gen;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic usr_load = 1'b0, usr_rst = 1'b0, cpu_halt = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0, tx_ready = 1'b1;
    logic cpu_rstn_b, cpu_rstn_l;
    logic [31:0] cc_b, cc_l;
    logic [5:0] led_b, led_l;

    always #5 clk = ~clk;

    cpu_ctrl_gen_if #(.BYTE_W(8), .WORD_W(32), .ADDR_W(AW)) bif ();
    cpu_ctrl_gen_if #(.BYTE_W(8), .WORD_W(32), .ADDR_W(AW)) lif ();

    assign bif.rx_data = rx_data;  assign lif.rx_data = rx_data;
    assign bif.rx_valid = rx_valid; assign lif.rx_valid = rx_valid;
    assign bif.tx_ready = tx_ready; assign lif.tx_ready = tx_ready;

    cpu_ctrl_gen #(.ADDR_W(AW), .INIT_WAIT(16), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rstn(rstn), .usr_load(usr_load), .usr_rst(usr_rst), .bus(bif),
        .cpu_rstn(cpu_rstn_b), .cpu_halt(cpu_halt), .clock_count(cc_b), .led_stat(led_b));
    cpu_ctrl_gen #(.ADDR_W(AW), .INIT_WAIT(16), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rstn(rstn), .usr_load(usr_load), .usr_rst(usr_rst), .bus(lif),
        .cpu_rstn(cpu_rstn_l), .cpu_halt(cpu_halt), .clock_count(cc_l), .led_stat(led_l));

    typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
    wr_t qb[$], ql[$];
    logic [7:0] qt[$];
    int n_cmp = 0, n_bad = 0, stalls = 0;
    logic [31:0] wtab[4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_cmp++; n_bad++;
        $display("FAIL %s: got an event, required none", nm);
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Monitors
    always @(negedge clk) begin
        wr_t e;
        logic [7:0] t;
        if (rstn) begin
            if (bif.imem_we) begin
                if (qb.size() == 0) unexpected("wr_be");
                else begin
                    e = qb.pop_front();
                    check("wr_be_addr", bif.imem_addr, e.a);
                    check("wr_be_data", bif.imem_wdata, e.d);
                end
            end
            if (lif.imem_we) begin
                if (ql.size() == 0) unexpected("wr_le");
                else begin
                    e = ql.pop_front();
                    check("wr_le_addr", lif.imem_addr, e.a);
                    check("wr_le_data", lif.imem_wdata, e.d);
                end
            end
            if (bif.tx_valid && tx_ready) begin
                if (qt.size() == 0) unexpected("tx");
                else begin
                    t = qt.pop_front();
                    check("tx_data", bif.tx_data, t);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_load();
        usr_load = 1'b1; tick(); usr_load = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        int n;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data = b; rx_valid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk); ok = bif.rx_ready; n++;
        end
        if (!ok) unexpected("rx_timeout");
        else if (n > 1) stalls++;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_size(input logic [31:0] n);
        send_byte(n[31:24], 0); send_byte(n[23:16], 0);
        send_byte(n[15:8], 0);  send_byte(n[7:0], 0);
    endtask

    task automatic load(input int n, input int gmax);
        logic [31:0] w;
        int bc;
        bc = 0;
        pulse_load();
        send_size(n);
        for (int i = 0; i < n; i++) begin
            w = (i < 4) ? wtab[i] : 32'hC0DE_0000 + i;
            if (i < 2**AW) begin
                qb.push_back('{a: AW'(i), d: w});
                ql.push_back('{a: AW'(i), d: bswap(w)});
            end
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[8*k +: 8], (gmax == 0) ? 0 : bc % (gmax + 1));
                bc++;
            end
        end
        qt.push_back(8'hAA);
    endtask

    task automatic wait_led(input logic [5:0] exp, input string nm);
        int n;
        n = 0;
        while (led_b !== exp && n < 200) begin @(negedge clk); n++; end
        check(nm, led_b, exp);
    endtask

    task automatic init_len();
        int c;
        wait_led(6'b000010, "enter_init");
        check("init_cpu_rstn", cpu_rstn_b, 1'b0);
        c = 0;
        while (led_b == 6'b000010 && c < 100) begin c++; @(negedge clk); end
        check("init_len", c, 16);
        check("run_led", led_b, 6'b000001);
        check("run_cpu_rstn", cpu_rstn_b, 1'b1);
    endtask

    task automatic run_halt(input int cyc);
        repeat (cyc) @(posedge clk);
        #1 cpu_halt = 1'b1;
        tick(); cpu_halt = 1'b0;
        @(negedge clk);
        check("end_led", led_b, 6'b000000);
        check("end_count_be", cc_b, cyc);
        check("end_count_le", cc_l, cyc);
        check("end_cpu_rstn", cpu_rstn_b, 1'b1);
    endtask

    initial begin
        #2 rstn = 1'b0;
        @(negedge clk);
        check("rst_led", led_b, 6'b100000);
        check("rst_cpu_rstn", cpu_rstn_b, 1'b0);
        check("rst_rx_ready", bif.rx_ready, 1'b0);
        check("rst_tx_valid", bif.tx_valid, 1'b0);
        check("rst_tx_data", bif.tx_data, 8'h00);
        check("rst_imem_we", bif.imem_we, 1'b0);
        check("rst_imem_addr", bif.imem_addr, 0);
        check("rst_count", cc_b, 0);
        @(posedge clk); #1 rstn = 1'b1;

        // Byte offered in IDLE is not taken.
        rx_data = 8'h5A; rx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_rx_ready", bif.rx_ready, 1'b0);
            check("idle_led", led_b, 6'b100000);
        end
        rx_valid = 1'b0;

        // Basic load, run 100, halt, restart.
        wtab[0] = 32'h1122_3344; wtab[1] = 32'h5566_7788;
        load(2, 0);
        init_len();
        run_halt(100);
        repeat (3) @(negedge clk);
        check("end_frozen", cc_b, 100);
        @(posedge clk); #1 usr_rst = 1'b1; tick(); usr_rst = 1'b0;
        @(negedge clk);
        check("rst_init_led", led_b, 6'b000010);
        check("rst_init_count", cc_b, 0);
        init_len();
        run_halt(7);

        // rx_valid gaps of 0..3 cycles.
        wtab[0] = 32'hDEAD_BEEF; wtab[1] = 32'h0102_0304;
        load(2, 3);
        init_len();

        // N=0 with tx_ready held low.
        tx_ready = 1'b0;
        load(0, 0);
        repeat (5) begin
            @(negedge clk);
            check("ack_hold_valid", bif.tx_valid, 1'b1);
            check("ack_hold_led", led_b, 6'b000100);
        end
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_led(6'b000001, "n0_run");

        // usr_load after 6 of 8 data bytes: only word 0 lands.
        pulse_load();
        send_size(2);
        qb.push_back('{a: '0, d: 32'hA1A2_A3A4});
        ql.push_back('{a: '0, d: 32'hA4A3_A2A1});
        send_byte(8'hA1, 0); send_byte(8'hA2, 0); send_byte(8'hA3, 0); send_byte(8'hA4, 0);
        send_byte(8'hB1, 0); send_byte(8'hB2, 0);
        pulse_load();
        @(negedge clk);
        check("reload_led", led_b, 6'b010000);
        wtab[0] = 32'hCAFE_F00D; wtab[1] = 32'h1357_9BDF;
        load(2, 0);
        wait_led(6'b000001, "reload_run");

        // Async reset in the middle of LD_DATA.
        pulse_load();
        send_size(2);
        qb.push_back('{a: '0, d: 32'h0A0B_0C0D});
        ql.push_back('{a: '0, d: 32'h0D0C_0B0A});
        send_byte(8'h0A, 0); send_byte(8'h0B, 0); send_byte(8'h0C, 0); send_byte(8'h0D, 0);
        send_byte(8'hEE, 0);
        rstn = 1'b0;
        #1;
        check("arst_led", led_b, 6'b100000);
        check("arst_imem_we", bif.imem_we, 1'b0);
        check("arst_tx_valid", bif.tx_valid, 1'b0);
        check("arst_rx_ready", bif.rx_ready, 1'b0);
        check("arst_cpu_rstn", cpu_rstn_b, 1'b0);
        @(negedge clk); rstn = 1'b1;
        tick();

        // Oversize load: the ninth word is discarded.
        wtab[0] = 32'h0000_0001; wtab[1] = 32'h0000_0002;
        wtab[2] = 32'h0000_0003; wtab[3] = 32'h0000_0004;
        load(2**AW + 1, 0);
        wait_led(6'b000001, "big_run");

        repeat (5) tick();
        check("qb_empty", qb.size(), 0);
        check("ql_empty", ql.size(), 0);
        check("qt_empty", qt.size(), 0);
        check("no_bubble", stalls, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end
endmodule
